// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - request/result signal bundle for the bit-serial adder/subtractor
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cy_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cy_out;
  logic             ovf;

  modport master (
    output start, sub, a, b, cy_in,
    input  busy, done, sum, cy_out, ovf
  );

  modport slave (
    input  start, sub, a, b, cy_in,
    output busy, done, sum, cy_out, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  serial_add_sub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cy_out_q;
  logic             ovf_q;

  // The single full-adder cell: operands shift right so bit 0 is always the current bit.
  logic s_bit;
  logic c_nxt;
  assign s_bit = op_a[0] ^ op_b[0] ^ carry;
  assign c_nxt = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; start is only honoured in IDLE and DONE, never while running.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
          last_bit  = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-bit shift/carry update and result publication on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      res      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cy_out_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
      if (accept) begin
        // Subtract is a + ~b + 1, so the mode lives entirely in op_b and the initial carry.
        op_a  <= bus.a;
        op_b  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub ? 1'b1 : bus.cy_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        carry <= c_nxt;
        res   <= {s_bit, res[WIDTH-1:1]};
        if (!last_bit) begin
          cnt <= cnt + CW'(1);
        end
        if (last_bit) begin
          // carry currently holds the carry into the MSB.
          sum_q    <= {s_bit, res[WIDTH-1:1]};
          cy_out_q <= c_nxt;
          ovf_q    <= carry ^ c_nxt;
        end
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sum    = sum_q;
  assign bus.cy_out = cy_out_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - self-checking bench for serial_add_sub at WIDTH 8 and WIDTH 2
module tb_serial_add_sub;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  serial_add_sub_if #(.WIDTH(8)) bus8 ();
  serial_add_sub_if #(.WIDTH(2)) bus2 ();

  serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_add_sub #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    logic       cy;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cy;
    logic       ovf;
  } vec_t;

  // Arithmetic reference: integer sums for sum/carry, signed range test for overflow.
  function automatic res_t model(input int w, input int a, input int b, input bit cin, input bit sub);
    res_t r;
    int m, half, bb, c, tot, sa, sb, sres;
    m    = (1 << w) - 1;
    half = 1 << (w - 1);
    bb   = sub ? ((~b) & m) : b;
    c    = sub ? 1 : int'(cin);
    tot  = a + bb + c;
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    sres = sub ? sa - sb : sa + sb + c;
    r.sum = 8'(tot & m);
    r.cy  = ((tot >> w) & 1) != 0;
    r.ovf = (sres > half - 1) || (sres < -half);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub,
                      output res_t got);
    logic [7:0] held;
    bit         steady;
    int         lat;
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cy_in = cin;
    bus8.sub   = sub;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    held   = bus8.sum;
    steady = 1'b1;
    lat    = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        lat = n;
        break;
      end
      if (!bus8.busy || bus8.sum !== held) steady = 1'b0;
    end
    check("latency8", lat, 8);
    check("run_steady", {31'd0, steady}, 1);
    got.sum = bus8.sum;
    got.cy  = bus8.cy_out;
    got.ovf = bus8.ovf;
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input bit cin, input bit sub,
                      output res_t got);
    int lat;
    bus2.start = 1'b1;
    bus2.a     = a;
    bus2.b     = b;
    bus2.cy_in = cin;
    bus2.sub   = sub;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (bus2.done) begin
        lat = n;
        break;
      end
    end
    check("latency2", lat, 2);
    got.sum = {6'd0, bus2.sum};
    got.cy  = bus2.cy_out;
    got.ovf = bus2.ovf;
  endtask

  task automatic cmp(input string name, input res_t got, input res_t exp);
    check({name, "_sum"}, {24'd0, got.sum}, {24'd0, exp.sum});
    check({name, "_cy"}, {31'd0, got.cy}, {31'd0, exp.cy});
    check({name, "_ovf"}, {31'd0, got.ovf}, {31'd0, exp.ovf});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    res_t got, exp;
    int   done_t[$];
    bit   no_done;

    total = 0;
    bad   = 0;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h10, cy: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, sub: 1'b0, sum: 8'h01, cy: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h80, cy: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h05, b: 8'h07, cin: 1'b0, sub: 1'b1, sum: 8'hFE, cy: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, cin: 1'b1, sub: 1'b1, sum: 8'h7F, cy: 1'b1, ovf: 1'b1};

    // T1: reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus8.start = 1'($urandom);
      bus8.sub   = 1'($urandom);
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      bus8.cy_in = 1'($urandom);
      bus2.start = 1'($urandom);
      bus2.sub   = 1'($urandom);
      bus2.a     = 2'($urandom);
      bus2.b     = 2'($urandom);
      bus2.cy_in = 1'($urandom);
      @(posedge clk);
    end
    #1;
    bus8.start = 1'b0;
    bus2.start = 1'b0;
    reset = 1'b0;
    check("rst_busy", {31'd0, bus8.busy}, 0);
    check("rst_done", {31'd0, bus8.done}, 0);
    check("rst_sum", {24'd0, bus8.sum}, 0);
    check("rst_cy", {31'd0, bus8.cy_out}, 0);
    check("rst_ovf", {31'd0, bus8.ovf}, 0);
    check("rst2_busy", {31'd0, bus2.busy}, 0);
    @(posedge clk);
    #1;

    // T2/T3: directed vectors
    for (int i = 0; i < 5; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, got);
      exp.sum = vecs[i].sum;
      exp.cy  = vecs[i].cy;
      exp.ovf = vecs[i].ovf;
      cmp($sformatf("vec%0d", i), got, exp);
    end
    @(posedge clk);
    #1;
    check("idle_after_done", {30'd0, bus8.busy, bus8.done}, 0);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      bit rc, rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      run8(ra, rb, rc, rs, got);
      cmp($sformatf("rnd%0d", i), got, model(8, int'(ra), int'(rb), rc, rs));
    end
    @(posedge clk);
    #1;

    // T4a: start pulse mid-run with different operands is ignored
    bus8.start = 1'b1;
    bus8.a = 8'h10;
    bus8.b = 8'h20;
    bus8.cy_in = 1'b0;
    bus8.sub = 1'b0;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus8.start = 1'b1;
    bus8.a = 8'hAA;
    bus8.sub = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    begin
      int n;
      n = 4;
      while (!bus8.done && n < 30) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("midrun_latency", n, 8);
    end
    check("midrun_sum", {24'd0, bus8.sum}, 32'h30);
    @(posedge clk);
    #1;
    check("midrun_no_restart", {31'd0, bus8.busy}, 0);

    // T4b: start held high -> back-to-back results every WIDTH+1 cycles
    bus8.start = 1'b1;
    bus8.a = 8'h33;
    bus8.b = 8'h11;
    bus8.sub = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        done_t.push_back(c);
        check("b2b_sum", {24'd0, bus8.sum}, 32'h22);
      end
    end
    bus8.start = 1'b0;
    check("b2b_count", done_t.size(), 4);
    if (done_t.size() >= 3) begin
      check("b2b_first", done_t[0], 9);
      check("b2b_gap1", done_t[1] - done_t[0], 9);
      check("b2b_gap2", done_t[2] - done_t[1], 9);
    end
    repeat (10) @(posedge clk);
    #1;

    // T5: reset on the 4th run edge discards the operation
    run8(8'h12, 8'h34, 1'b0, 1'b0, got);
    check("pre_rst_sum", {24'd0, got.sum}, 32'h46);
    @(posedge clk);
    #1;
    bus8.start = 1'b1;
    bus8.a = 8'hF0;
    bus8.b = 8'hF0;
    bus8.sub = 1'b0;
    bus8.cy_in = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, bus8.busy}, 0);
    check("mid_rst_done", {31'd0, bus8.done}, 0);
    check("mid_rst_sum", {24'd0, bus8.sum}, 0);
    check("mid_rst_cy", {31'd0, bus8.cy_out}, 0);
    check("mid_rst_ovf", {31'd0, bus8.ovf}, 0);
    no_done = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus8.done || bus8.busy) no_done = 1'b0;
    end
    check("mid_rst_quiet", {31'd0, no_done}, 1);
    run8(8'hF0, 8'hF0, 1'b1, 1'b0, got);
    cmp("post_rst", got, model(8, 'hF0, 'hF0, 1'b1, 1'b0));

    // T6: exhaustive WIDTH=2
    for (int k = 0; k < 64; k++) begin
      logic [1:0] ea, eb;
      bit ec, es;
      ea = 2'(k & 3);
      eb = 2'((k >> 2) & 3);
      ec = ((k >> 4) & 1) != 0;
      es = ((k >> 5) & 1) != 0;
      run2(ea, eb, ec, es, got);
      cmp($sformatf("w2_%0d", k), got, model(2, int'(ea), int'(eb), ec, es));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
